serie_paralelo_rx: RTL and testbench
====================================

// Module: serie_paralelo_rx
// PURPOSE
//  Downstream receiver for the 16-bit parallel-to-serial test stage. It deserializes the
//  LSB-first bit stream (bit k sent while the upstream counter = k) back into 16-bit words.
//  It aligns to a frame-sync strobe and presents each word with a valid/ready handshake
//  to the ADC-test capture logic.
// PARAMETERS
//  WIDTH  16  bits per word; must equal the upstream word width
//  CNT_W  4   bit-index counter width, clog2(WIDTH)
// PORTS
//  clk          in   1      system clock, single domain
//  reset        in   1      synchronous, active-high reset
//  bit_en       in   1      bit strobe; serial_in is sampled only on cycles with bit_en=1
//  serial_in    in   1      serial data, LSB first
//  frame_sync   in   1      qualified by bit_en: the current bit is bit 0 of a word
//  datos_out    out  WIDTH  last completed word
//  dato_valido  out  1      datos_out holds an unconsumed word
//  dato_listo   in   1      consumer ready; transfer occurs when valido&listo
//  overrun      out  1      1-cycle pulse: a completed word was dropped
//  sync_err     out  1      1-cycle pulse: frame_sync arrived mid-word
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, shift reg=0, datos_out=0, dato_valido=0, overrun=0, sync_err=0.
//  FSM:
//   - IDLE: ignore all bits until bit_en&frame_sync. On that cycle, store serial_in at
//     index 0, set cnt=1, go to SHIFT.
//   - SHIFT: on bit_en, store serial_in at index cnt and increment cnt.
//   - At cnt=WIDTH-1: store the last bit, wrap cnt to 0, raise word-complete, stay in SHIFT.
//     The receiver free-runs like the upstream counter; no resync is needed per word.
//   - frame_sync in SHIFT with cnt!=0: discard the partial word, store the bit at index 0,
//     set cnt=1, and pulse sync_err. frame_sync with cnt=0 is the normal case (no error).
//  Output register, on word-complete (registered; datos_out updates the cycle after the
//  last bit, so latency = 1 clk):
//   - dato_valido=0: load datos_out, set valido=1.
//   - valido=1 and listo=1 in the same cycle: the old word transfers, the new word loads,
//     valido stays 1, no overrun.
//   - valido=1 and listo=0: keep the old word, drop the new one, pulse overrun.
//  With no word-complete, valido&listo clears valido; datos_out holds its value.
//  bit_en=0: all state holds. Reset mid-word: the partial word is lost and the FSM returns
//  to IDLE.
//  Pulses (overrun, sync_err) are registered and high for exactly one clk.
// CONFIGURATION
//  OVERRUN_CNT_EN defined:
//   - adds output overrun_cnt [7:0], a saturating count of overrun pulses (holds at 255).
//   - cleared by reset.
//  OVERRUN_CNT_EN undefined: no port, no counter; the overrun pulse is unchanged.
// STRUCTURE
//  Shared package (serie_paralelo_pkg): WIDTH, CNT_W, FSM encoding (IDLE=1'b0, SHIFT=1'b1).
//  One sub-module, contador_bits_rx: CNT_W counter with enable, synchronous load-to-1 on
//  sync, wrap flag at WIDTH-1. The top holds the FSM, shift register and output handshake.
// TESTING
//  1. reset; bit_en each clk, frame_sync at bit 0, stream 16'hA5C3 LSB first, listo=1
//     -> datos_out=A5C3, valido=1 one clk after bit 15.
//  2. two back-to-back words 16'h1234, 16'hFFFF with listo=0 throughout
//     -> datos_out stays 1234, overrun pulses once, valido=1.
//  3. frame_sync at bit 7 of a word, then a full 16'h00FF
//     -> sync_err pulses once; the next word is 00FF with no corrupt word emitted.
//  4. listo asserted in the same cycle as word-complete (words 16'h0001, 16'h0002)
//     -> 0001 consumed, 0002 loaded, valido stays 1, no overrun.
//  5. bit_en toggling 1-in-3 cycles with word 16'h8001
//     -> same result as continuous; state frozen on bit_en=0.
//  6. reset at bit 9, then a full 16'hBEEF
//     -> valido=0 after reset; the first word out is BEEF.
//  7. OVERRUN_CNT_EN defined: 300 forced overruns -> overrun_cnt=255.

Source files
------------

// File: rtl/serie_paralelo_pkg.sv
// Shared definitions for the serial-to-parallel receiver.
//   WIDTH : bits per word. It must equal the upstream word width.
//   CNT_W : width of the bit-index counter, clog2(WIDTH).
//   rx_state_t : receiver FSM encoding (IDLE=0, SHIFT=1).
package serie_paralelo_pkg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;
endpackage

// File: rtl/serie_paralelo_rx_contador_bits.sv
// contador_bits_rx: bit-index counter for the receiver.
//   clk, reset : system clock and synchronous active-high reset
//   en         : advance or load on this cycle
//   sync_load  : with en, load 1. The current bit is bit 0, so the next bit is bit 1.
//   cnt        : index of the bit that the next strobe stores
//   wrap       : cnt is at the last bit (WIDTH-1). The next enabled step wraps to 0.
module contador_bits_rx
  import serie_paralelo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_load,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (en) begin
      if (sync_load)
        cnt <= CNT_W'(1);
      else if (wrap)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/serie_paralelo_rx.sv
// serie_paralelo_rx: deserializes an LSB-first bit stream into WIDTH-bit words.
// The receiver aligns to frame_sync. It presents each word with a valid/ready handshake.
//   clk, reset  : system clock and synchronous active-high reset
//   bit_en      : bit strobe. serial_in and frame_sync are used only when bit_en=1.
//   serial_in   : serial data, LSB first
//   frame_sync  : the current bit is bit 0 of a word
//   datos_out   : last completed word
//   dato_valido : datos_out holds an unconsumed word
//   dato_listo  : consumer ready
//   overrun     : 1-clk pulse. A completed word was dropped.
//   sync_err    : 1-clk pulse. frame_sync arrived in the middle of a word.
//   overrun_cnt : saturating count of overruns. Present only if OVERRUN_CNT_EN is defined.
//   state_dbg   : current FSM state (0=IDLE, 1=SHIFT)
// Handshake: a word transfers on every clk where dato_valido && dato_listo.
//   dato_valido never depends combinationally on dato_listo.
//   Once dato_valido is raised, datos_out is stable until that transfer.
module serie_paralelo_rx
  import serie_paralelo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             serial_in,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] datos_out,
  output logic             dato_valido,
  input  logic             dato_listo,
  output logic             overrun,
  output logic             sync_err,
`ifdef OVERRUN_CNT_EN
  output logic [7:0]       overrun_cnt,
`endif
  output logic             state_dbg
);
  rx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_wrap, cnt_en, cnt_load;
  logic             restart, store_bit, word_done, sync_err_next, drop;
  // The last bit goes straight into the output word, so only WIDTH-1 bits are held here.
  logic [WIDTH-2:0] shift_q;
  logic [WIDTH-1:0] word;

  contador_bits_rx u_cnt (
    .clk       (clk),
    .reset     (reset),
    .en        (cnt_en),
    .sync_load (cnt_load),
    .cnt       (cnt),
    .wrap      (cnt_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    cnt_en        = 1'b0;
    cnt_load      = 1'b0;
    restart       = 1'b0;
    store_bit     = 1'b0;
    word_done     = 1'b0;
    sync_err_next = 1'b0;
    case (state)
      IDLE: begin
        if (bit_en && frame_sync) begin
          state_next = SHIFT;
          cnt_en     = 1'b1;
          cnt_load   = 1'b1;
          restart    = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          cnt_en = 1'b1;
          if (frame_sync) begin
            // frame_sync at cnt=0 is the normal word boundary.
            // Anywhere else, the partial word is discarded.
            cnt_load      = 1'b1;
            restart       = 1'b1;
            sync_err_next = (cnt != '0);
          end else begin
            store_bit = ~cnt_wrap;
            word_done = cnt_wrap;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      shift_q <= '0;
    else if (restart)
      shift_q <= {{(WIDTH-2){1'b0}}, serial_in};
    else if (store_bit)
      shift_q[cnt] <= serial_in;
  end

  assign word = {serial_in, shift_q};
  // A new word is dropped only when the held word is not consumed on this cycle.
  assign drop = word_done & dato_valido & ~dato_listo;

  always_ff @(posedge clk) begin
    if (reset) begin
      datos_out   <= '0;
      dato_valido <= 1'b0;
      overrun     <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      overrun  <= drop;
      sync_err <= sync_err_next;
      if (word_done) begin
        if (!drop) begin
          datos_out   <= word;
          dato_valido <= 1'b1;
        end
      end else if (dato_valido && dato_listo) begin
        dato_valido <= 1'b0;
      end
    end
  end

`ifdef OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      overrun_cnt <= '0;
    else if (drop && overrun_cnt != 8'hFF)
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

  assign state_dbg = state;
endmodule

// File: tb/tb_serie_paralelo_rx.sv
// Bench for serie_paralelo_rx.
// A word-level model tracks the expected outputs.
// A negedge compare process checks the DUT against the model on every cycle.
// Directed scenarios add literal expectations.
// Define OVERRUN_CNT_EN to also cover the overrun counter.
module tb_serie_paralelo_rx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bit_en = 1'b0;
  logic        serial_in = 1'b0;
  logic        frame_sync = 1'b0;
  logic        dato_listo = 1'b0;
  logic [15:0] datos_out;
  logic        dato_valido, overrun, sync_err, state_dbg;
`ifdef OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  int ovr_seen = 0;
  int serr_seen = 0;

  // Model state
  bit          in_frame = 1'b0;
  int          pos = 0;
  logic [15:0] acc = '0;
  logic [15:0] m_data = '0;
  bit          m_valid = 1'b0, m_ovr = 1'b0, m_serr = 1'b0;
  int          m_ocnt = 0;

  serie_paralelo_rx dut (
    .clk         (clk),
    .reset       (reset),
    .bit_en      (bit_en),
    .serial_in   (serial_in),
    .frame_sync  (frame_sync),
    .datos_out   (datos_out),
    .dato_valido (dato_valido),
    .dato_listo  (dato_listo),
    .overrun     (overrun),
    .sync_err    (sync_err),
`ifdef OVERRUN_CNT_EN
    .overrun_cnt (overrun_cnt),
`endif
    .state_dbg   (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Word-level model, applied once per clock using the inputs of that clock.
  task automatic model_clock();
    bit          done;
    logic [15:0] w;
    done   = 1'b0;
    w      = '0;
    m_ovr  = 1'b0;
    m_serr = 1'b0;
    if (reset) begin
      in_frame = 1'b0; pos = 0; acc = '0;
      m_data = '0; m_valid = 1'b0; m_ocnt = 0;
      return;
    end
    if (bit_en) begin
      if (frame_sync) begin
        if (in_frame && pos != 0) m_serr = 1'b1;
        in_frame = 1'b1;
        acc      = '0;
        acc[0]   = serial_in;
        pos      = 1;
      end else if (in_frame) begin
        acc[pos] = serial_in;
        pos++;
        if (pos == 16) begin
          done = 1'b1;
          w    = acc;
          pos  = 0;
        end
      end
    end
    if (done) begin
      if (!m_valid || dato_listo) begin
        m_data  = w;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
        if (m_ocnt < 255) m_ocnt++;
      end
    end else if (m_valid && dato_listo) begin
      m_valid = 1'b0;
    end
  endtask

  // Driver: apply the inputs for one clock, then advance the model.
  task automatic step(input logic be, input logic s, input logic fs, input logic li,
                      input logic rst = 1'b0);
    reset      = rst;
    bit_en     = be;
    serial_in  = s;
    frame_sync = fs;
    dato_listo = li;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input logic li);
    for (int i = 0; i < 16; i++) step(1'b1, w[i], i == 0, li);
  endtask

  task automatic idle(input int n, input logic li);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, li);
  endtask

  // Compare process
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("datos_out", 32'(datos_out), 32'(m_data));
        check("dato_valido", 32'(dato_valido), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("sync_err", 32'(sync_err), 32'(m_serr));
        check("state_dbg", 32'(state_dbg), 32'(in_frame));
`ifdef OVERRUN_CNT_EN
        check("overrun_cnt", 32'(overrun_cnt), 32'(m_ocnt));
`endif
        if (overrun === 1'b1) ovr_seen++;
        if (sync_err === 1'b1) serr_seen++;
      end
    end
  end

  initial begin
    int o0, s0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp_en = 1'b1;
    check("reset_datos", 32'(datos_out), 32'h0);
    check("reset_valido", 32'(dato_valido), 32'h0);
    check("reset_state", 32'(state_dbg), 32'h0);

    // 1: single word, consumer ready. The word appears one clk after bit 15.
    send_word(16'hA5C3, 1'b1);
    check("t1_datos", 32'(datos_out), 32'hA5C3);
    check("t1_valido", 32'(dato_valido), 32'h1);
    check("t1_model", 32'(m_data), 32'hA5C3);
    idle(1, 1'b1);
    check("t1_consumed", 32'(dato_valido), 32'h0);

    // 2: two words back to back, consumer never ready.
    o0 = ovr_seen;
    send_word(16'h1234, 1'b0);
    send_word(16'hFFFF, 1'b0);
    check("t2_ovr_pulse", 32'(overrun), 32'h1);
    idle(2, 1'b0);
    check("t2_datos", 32'(datos_out), 32'h1234);
    check("t2_valido", 32'(dato_valido), 32'h1);
    check("t2_ovr_count", 32'(ovr_seen - o0), 32'd1);
    idle(1, 1'b1);

    // 3: frame_sync at bit 7 of a word, then a full word.
    s0 = serr_seen;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, i == 0, 1'b0);
    send_word(16'h00FF, 1'b0);
    idle(1, 1'b0);
    check("t3_datos", 32'(datos_out), 32'h00FF);
    check("t3_serr_count", 32'(serr_seen - s0), 32'd1);
    idle(1, 1'b1);

    // 4: consumer ready in the same cycle as word-complete.
    o0 = ovr_seen;
    send_word(16'h0001, 1'b0);
    check("t4_first", 32'(datos_out), 32'h0001);
    for (int i = 0; i < 16; i++) step(1'b1, 16'h0002 >> i, i == 0, i == 15);
    idle(1, 1'b0);
    check("t4_datos", 32'(datos_out), 32'h0002);
    check("t4_valido", 32'(dato_valido), 32'h1);
    check("t4_no_ovr", 32'(ovr_seen - o0), 32'd0);
    idle(1, 1'b1);

    // 5: bit_en 1-in-3. Junk on serial_in/frame_sync while bit_en=0 must be ignored.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      step(1'b1, 16'h8001 >> i, i == 0, 1'b0);
    end
    check("t5_datos", 32'(datos_out), 32'h8001);
    check("t5_valido", 32'(dato_valido), 32'h1);

    // 6: reset at bit 9, bits without frame_sync while IDLE, then a full word.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, i == 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t6_rst_valido", 32'(dato_valido), 32'h0);
    check("t6_rst_datos", 32'(datos_out), 32'h0);
    check("t6_rst_state", 32'(state_dbg), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t6_idle_state", 32'(state_dbg), 32'h0);
    send_word(16'hBEEF, 1'b0);
    check("t6_datos", 32'(datos_out), 32'hBEEF);
    check("t6_valido", 32'(dato_valido), 32'h1);

`ifdef OVERRUN_CNT_EN
    // 7: 300 forced overruns saturate the counter.
    for (int n = 0; n < 300; n++) send_word(16'h0F0F, 1'b0);
    idle(1, 1'b0);
    check("t7_ovr_cnt", 32'(overrun_cnt), 32'd255);
    check("t7_datos", 32'(datos_out), 32'hBEEF);
`endif

    idle(2, 1'b0);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
